// File: rtl/alt_vipvfr130_vfr_buffer_scheduler.sv
// Four-buffer frame rotation that programs the VFR slave in place of software.
// Hands free buffers to the writer and commits finished frames on each VFR irq.
module alt_vipvfr130_vfr_buffer_scheduler #(
    parameter int NUM_BUFFERS = 4,
    parameter int IDX_WIDTH   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          cfg_base_address,
    input  logic [31:0]          cfg_stride,
    input  logic [31:0]          cfg_words,
    input  logic [31:0]          cfg_samples,
    input  logic [15:0]          cfg_width,
    input  logic [15:0]          cfg_height,
    input  logic [3:0]           cfg_interlaced,
    output logic [IDX_WIDTH-1:0] wr_buffer,
    input  logic                 wr_frame_done,
    output logic [IDX_WIDTH-1:0] rd_buffer,
    output logic [4:0]           av_address,
    output logic                 av_write,
    output logic [31:0]          av_writedata,
    input  logic                 av_waitrequest,
    input  logic                 vfr_irq,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_PROG, S_SELECT, S_GO,
        S_CLR_IRQ, S_DECIDE, S_WAIT_IRQ, S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] rd_q, rd_d;
    logic [IDX_WIDTH-1:0] prev_rd_q, prev_rd_d;
    logic [IDX_WIDTH-1:0] ready_q, ready_d;
    logic                 ready_v_q, ready_v_d;
    logic [IDX_WIDTH-1:0] target_q, target_d;
    logic [IDX_WIDTH-1:0] wr_buffer_q, wr_buffer_d;
    logic                 bank_q, bank_d;
    logic                 first_q, first_d;
    logic [2:0]           step_q, step_d;
    logic                 av_write_q, av_write_d;
    logic [4:0]           av_address_q, av_address_d;
    logic [31:0]          av_writedata_q, av_writedata_d;

    logic                 wr_done;
    logic                 nb;
    logic [31:0]          buf_addr;
    logic [4:0]           bank_off;
    logic [4:0]           prog_off;
    logic                 iss;
    logic [4:0]           iss_addr;
    logic [31:0]          iss_data;
    logic                 found;

    assign wr_buffer    = wr_buffer_q;
    assign rd_buffer    = rd_q;
    assign av_address   = av_address_q;
    assign av_write     = av_write_q;
    assign av_writedata = av_writedata_q;
    assign busy         = (state_q != S_IDLE);

    assign wr_done  = av_write_q & ~av_waitrequest;
    assign nb       = ~bank_q;
    assign buf_addr = cfg_base_address + cfg_stride * 32'(target_q);
    assign bank_off = nb ? 5'd11 : 5'd4;
    assign prog_off = (step_q >= 3'd3) ? {2'b00, step_q} + 5'd1
                                       : {2'b00, step_q};

    // Sequencer: one slave write per step, buffer bookkeeping, free-buffer pick
    always_comb begin
        state_d        = state_q;
        rd_d           = rd_q;
        prev_rd_d      = prev_rd_q;
        ready_d        = ready_q;
        ready_v_d      = ready_v_q;
        target_d       = target_q;
        bank_d         = bank_q;
        first_d        = first_q;
        step_d         = step_q;
        av_write_d     = av_write_q & av_waitrequest;
        av_address_d   = av_address_q;
        av_writedata_d = av_writedata_q;
        iss            = 1'b0;
        iss_addr       = 5'd0;
        iss_data       = 32'd0;
        wr_buffer_d    = '0;
        found          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_PROG;
                    target_d = ready_v_q ? ready_q : '0;
                    bank_d   = 1'b1;
                    first_d  = 1'b1;
                    step_d   = 3'd0;
                end
            end
            S_PROG: begin
                iss      = 1'b1;
                iss_addr = bank_off + prog_off;
                unique case (step_q)
                    3'd0:    iss_data = buf_addr;
                    3'd1:    iss_data = cfg_words;
                    3'd2:    iss_data = cfg_samples;
                    3'd3:    iss_data = {16'd0, cfg_width};
                    3'd4:    iss_data = {16'd0, cfg_height};
                    default: iss_data = {28'd0, cfg_interlaced};
                endcase
                if (wr_done) begin
                    if (step_q == 3'd5) state_d = S_SELECT;
                    else step_d = step_q + 3'd1;
                end
            end
            S_SELECT: begin
                iss      = 1'b1;
                iss_addr = 5'd3;
                iss_data = 32'(nb);
                if (wr_done) begin
                    bank_d    = nb;
                    prev_rd_d = rd_q;
                    rd_d      = target_q;
                    ready_v_d = 1'b0;
                    if (first_q) state_d = S_GO;
                    else state_d = enable ? S_WAIT_IRQ : S_STOP;
                end
            end
            S_GO: begin
                iss      = 1'b1;
                iss_addr = 5'd0;
                iss_data = 32'h3;
                if (wr_done) begin
                    first_d = 1'b0;
                    state_d = enable ? S_WAIT_IRQ : S_STOP;
                end
            end
            S_WAIT_IRQ: begin
                if (vfr_irq) state_d = S_CLR_IRQ;
                else if (!enable) state_d = S_STOP;
            end
            S_CLR_IRQ: begin
                iss      = 1'b1;
                iss_addr = 5'd2;
                iss_data = 32'h1;
                if (wr_done) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (ready_v_q) begin
                    target_d = ready_q;
                    step_d   = 3'd0;
                    state_d  = S_PROG;
                end else begin
                    prev_rd_d = rd_q;
                    state_d   = enable ? S_WAIT_IRQ : S_STOP;
                end
            end
            S_STOP: begin
                iss      = 1'b1;
                iss_addr = 5'd0;
                iss_data = 32'h0;
                if (wr_done) state_d = S_IDLE;
            end
        endcase

        if (iss && !av_write_q) begin
            av_write_d     = 1'b1;
            av_address_d   = iss_addr;
            av_writedata_d = iss_data;
        end

        if (wr_frame_done) begin
            ready_d   = wr_buffer_q;
            ready_v_d = 1'b1;
        end

        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (!found &&
                IDX_WIDTH'(i) != rd_q &&
                IDX_WIDTH'(i) != prev_rd_q &&
                !(ready_v_q && IDX_WIDTH'(i) == ready_q)) begin
                wr_buffer_d = IDX_WIDTH'(i);
                found       = 1'b1;
            end
        end
    end

    // State and output registers; reset drops any write in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rd_q           <= '0;
            prev_rd_q      <= '0;
            ready_q        <= '0;
            ready_v_q      <= 1'b0;
            target_q       <= '0;
            wr_buffer_q    <= '0;
            bank_q         <= 1'b1;
            first_q        <= 1'b0;
            step_q         <= 3'd0;
            av_write_q     <= 1'b0;
            av_address_q   <= 5'd0;
            av_writedata_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            rd_q           <= rd_d;
            prev_rd_q      <= prev_rd_d;
            ready_q        <= ready_d;
            ready_v_q      <= ready_v_d;
            target_q       <= target_d;
            wr_buffer_q    <= wr_buffer_d;
            bank_q         <= bank_d;
            first_q        <= first_d;
            step_q         <= step_d;
            av_write_q     <= av_write_d;
            av_address_q   <= av_address_d;
            av_writedata_q <= av_writedata_d;
        end
    end

endmodule

// File: tb/tb_alt_vipvfr130_vfr_buffer_scheduler.sv
// Bench for the VFR buffer scheduler: transaction-level model of the
// buffer rotation and expected slave write stream, random stalls and events.
module tb_alt_vipvfr130_vfr_buffer_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] cfg_base_address, cfg_stride, cfg_words, cfg_samples;
    logic [15:0] cfg_width, cfg_height;
    logic [3:0]  cfg_interlaced;
    logic [1:0]  wr_buffer, rd_buffer;
    logic        wr_frame_done;
    logic [4:0]  av_address;
    logic        av_write;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic        vfr_irq;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] seen[$];
    logic [36:0] exp_q[$];

    int m_rd, m_prev, m_ready;
    bit m_rv, m_bank;

    always #5 clock = ~clock;

    alt_vipvfr130_vfr_buffer_scheduler #(.NUM_BUFFERS(4), .IDX_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .cfg_base_address(cfg_base_address), .cfg_stride(cfg_stride),
        .cfg_words(cfg_words), .cfg_samples(cfg_samples),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_interlaced(cfg_interlaced),
        .wr_buffer(wr_buffer), .wr_frame_done(wr_frame_done),
        .rd_buffer(rd_buffer), .av_address(av_address), .av_write(av_write),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
        .vfr_irq(vfr_irq), .busy(busy)
    );

    // Slave side: log every accepted write
    always @(posedge clock)
        if (!reset && av_write && !av_waitrequest)
            seen.push_back({av_address, av_writedata});

    task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic int m_wr();
        for (int i = 0; i < 4; i++)
            if (i != m_rd && i != m_prev && !(m_rv && i == m_ready))
                return i;
        return 0;
    endfunction

    task automatic m_reset();
        m_rd = 0; m_prev = 0; m_ready = 0; m_rv = 0; m_bank = 1;
    endtask

    task automatic m_prog(int t);
        logic [31:0] a;
        logic [4:0]  b;
        bit          nbk;
        nbk = ~m_bank;
        b   = nbk ? 5'd11 : 5'd4;
        a   = cfg_base_address + cfg_stride * 32'(t);
        exp_q.push_back({b,        a});
        exp_q.push_back({b + 5'd1, cfg_words});
        exp_q.push_back({b + 5'd2, cfg_samples});
        exp_q.push_back({b + 5'd4, {16'd0, cfg_width}});
        exp_q.push_back({b + 5'd5, {16'd0, cfg_height}});
        exp_q.push_back({b + 5'd6, {28'd0, cfg_interlaced}});
        exp_q.push_back({5'd3, 32'(nbk)});
        m_prev = m_rd; m_rd = t; m_rv = 0; m_bank = nbk;
    endtask

    task automatic m_start();
        m_bank = 1;
        m_prog(m_rv ? m_ready : 0);
        exp_q.push_back({5'd0, 32'h3});
    endtask

    task automatic m_irq();
        exp_q.push_back({5'd2, 32'h1});
        if (m_rv) m_prog(m_ready);
        else m_prev = m_rd;
    endtask

    task automatic frame_done();
        @(negedge clock);
        expect_eq("wr_buffer_at_done", 32'(wr_buffer), 32'(m_wr()));
        wr_frame_done = 1'b1;
        @(negedge clock);
        wr_frame_done = 1'b0;
        m_ready = m_wr(); m_rv = 1;
        @(negedge clock);
    endtask

    task automatic drain(int stall_at, int drop_at, bit rnd);
        int          cyc = 0;
        int          st = 0;
        bit          prev_stall = 0;
        logic [4:0]  pa = '0;
        logic [31:0] pd = '0;
        int          n = exp_q.size();
        while (seen.size() < n && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (prev_stall) begin
                expect_eq("hold_addr", 32'(av_address), 32'(pa));
                expect_eq("hold_data", av_writedata, pd);
            end
            if (vfr_irq && seen.size() > 0 && seen[0][36:32] == 5'd2)
                vfr_irq = 1'b0;
            if (drop_at >= 0 && seen.size() >= drop_at)
                enable = 1'b0;
            if (av_write && stall_at >= 0 && seen.size() == stall_at && st < 3) begin
                av_waitrequest = 1'b1;
                st++;
            end else begin
                av_waitrequest = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            prev_stall = av_write && av_waitrequest;
            pa = av_address;
            pd = av_writedata;
        end
        av_waitrequest = 1'b0;
        vfr_irq = 1'b0;
        repeat (4) @(negedge clock);
        if (stall_at >= 0) expect_eq("stall_applied", 32'(st), 32'd3);
        expect_eq("write_count", 32'(seen.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < seen.size()) begin
                expect_eq("write_addr", 32'(seen[i][36:32]), 32'(exp_q[i][36:32]));
                expect_eq("write_data", seen[i][31:0], exp_q[i][31:0]);
            end
        end
        seen.delete();
        exp_q.delete();
    endtask

    task automatic irq_seq(int stall_at, bit rnd);
        vfr_irq = 1'b1;
        m_irq();
        drain(stall_at, -1, rnd);
    endtask

    task automatic state_chk(bit busy_exp);
        expect_eq("rd_buffer", 32'(rd_buffer), 32'(m_rd));
        expect_eq("wr_buffer", 32'(wr_buffer), 32'(m_wr()));
        expect_eq("busy", 32'(busy), 32'(busy_exp));
    endtask

    task automatic rand_cfg();
        cfg_base_address = $urandom;
        cfg_stride       = $urandom;
        cfg_words        = $urandom;
        cfg_samples      = $urandom;
        cfg_width        = 16'($urandom);
        cfg_height       = 16'($urandom);
        cfg_interlaced   = 4'($urandom);
    endtask

    initial begin
        int w;
        reset = 1'b1; enable = 1'b0; wr_frame_done = 1'b0;
        av_waitrequest = 1'b0; vfr_irq = 1'b0;
        rand_cfg();
        repeat (3) @(negedge clock);
        expect_eq("rst_av_write", 32'(av_write), 32'd0);
        expect_eq("rst_av_address", 32'(av_address), 32'd0);
        expect_eq("rst_av_writedata", av_writedata, 32'd0);
        expect_eq("rst_busy", 32'(busy), 32'd0);
        expect_eq("rst_rd", 32'(rd_buffer), 32'd0);
        expect_eq("rst_wr", 32'(wr_buffer), 32'd0);
        reset = 1'b0;
        m_reset();
        @(negedge clock);
        expect_eq("wr_after_rst", 32'(wr_buffer), 32'd1);

        cfg_base_address = 32'h1000_0000;
        cfg_stride       = 32'h0080_0000;
        enable = 1'b1;
        m_start();
        drain(-1, -1, 0);
        state_chk(1);

        frame_done();
        irq_seq(-1, 0);
        state_chk(1);

        irq_seq(-1, 0);
        state_chk(1);

        frame_done();
        frame_done();
        irq_seq(-1, 0);
        state_chk(1);

        frame_done();
        irq_seq(2, 0);
        state_chk(1);

        for (int k = 0; k < 40; k++) begin
            rand_cfg();
            if ($urandom_range(0, 1) == 1) frame_done();
            else irq_seq(-1, 1);
            state_chk(1);
        end

        frame_done();
        vfr_irq = 1'b1;
        m_irq();
        exp_q.push_back({5'd0, 32'h0});
        drain(-1, 2, 1);
        state_chk(0);

        frame_done();
        enable = 1'b1;
        m_start();
        drain(-1, -1, 1);
        state_chk(1);

        vfr_irq = 1'b1;
        av_waitrequest = 1'b1;
        w = 0;
        while (!av_write && w < 20) begin
            @(negedge clock);
            w++;
        end
        expect_eq("write_pending", 32'(av_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        expect_eq("rst_abandon_write", 32'(av_write), 32'd0);
        expect_eq("rst_abandon_busy", 32'(busy), 32'd0);
        expect_eq("rst_abandon_rd", 32'(rd_buffer), 32'd0);
        vfr_irq = 1'b0;
        av_waitrequest = 1'b0;
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        m_reset();
        seen.delete();
        exp_q.delete();
        repeat (2) @(negedge clock);
        state_chk(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
